// File: rtl/biu_bus_arbiter_pkg.sv
// Shared widths, arbiter state encoding and command-type helpers for biu_bus_arbiter.
package biu_bus_arbiter_pkg;

  localparam int FCU_IADDR_WIDTH = 32;
  localparam int FCU_DDATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic wt;
    logic line;
    logic read;
  } cmd_type_t;

  // A port may raise several type bits at once; exactly one survives, wt > line > read.
  function automatic cmd_type_t pick_type(input logic wt, input logic line, input logic read);
    cmd_type_t t;
    t.wt   = wt;
    t.line = ~wt & line;
    t.read = ~wt & ~line & read;
    return t;
  endfunction

endpackage

// File: rtl/biu_bus_arbiter_if.sv
// Request/response bundle between the two biu_cell ports, the arbiter and the cache bus unit.
interface biu_bus_arbiter_if
  import biu_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = FCU_IADDR_WIDTH,
  parameter int DATA_W = FCU_DDATA_WIDTH
);
  // Requests are levels held until trans_rdy/bus_error; trans_rdy/bus_error are 1-cycle pulses.
  logic              p0_wt_req, p0_read_req, p0_line_req;
  logic [3:0]        p0_size;
  logic [ADDR_W-1:0] p0_pa;
  logic [DATA_W-1:0] p0_wt_data;
  logic              p0_line_write, p0_entry_write, p0_trans_rdy, p0_bus_error;
  logic              p1_wt_req, p1_read_req, p1_line_req;
  logic [3:0]        p1_size;
  logic [ADDR_W-1:0] p1_pa;
  logic [DATA_W-1:0] p1_wt_data;
  logic              p1_line_write, p1_entry_write, p1_trans_rdy, p1_bus_error;
  logic [63:0]       line_data_o;
  logic [10:0]       addr_count_o;
  logic              wt_req, read_req, line_req;
  logic [3:0]        size_o;
  logic [ADDR_W-1:0] pa_o;
  logic [DATA_W-1:0] wt_data_o;
  logic [63:0]       line_data;
  logic [10:0]       addr_count;
  logic              line_write, cache_entry_write, trans_rdy, bus_error;
  logic [1:0]        owner;
  arb_state_e        state;

  modport slave (
    input  p0_wt_req, p0_read_req, p0_line_req, p0_size, p0_pa, p0_wt_data,
    input  p1_wt_req, p1_read_req, p1_line_req, p1_size, p1_pa, p1_wt_data,
    input  line_data, addr_count, line_write, cache_entry_write, trans_rdy, bus_error,
    output p0_line_write, p0_entry_write, p0_trans_rdy, p0_bus_error,
    output p1_line_write, p1_entry_write, p1_trans_rdy, p1_bus_error,
    output line_data_o, addr_count_o, wt_req, read_req, line_req, size_o, pa_o, wt_data_o,
    output owner, state
  );

  modport master (
    output p0_wt_req, p0_read_req, p0_line_req, p0_size, p0_pa, p0_wt_data,
    output p1_wt_req, p1_read_req, p1_line_req, p1_size, p1_pa, p1_wt_data,
    output line_data, addr_count, line_write, cache_entry_write, trans_rdy, bus_error,
    input  p0_line_write, p0_entry_write, p0_trans_rdy, p0_bus_error,
    input  p1_line_write, p1_entry_write, p1_trans_rdy, p1_bus_error,
    input  line_data_o, addr_count_o, wt_req, read_req, line_req, size_o, pa_o, wt_data_o,
    input  owner, state
  );

endinterface

// File: rtl/biu_bus_arbiter_rr_pick.sv
// 2-way chooser: a lone requester wins; a tie goes to port 1 when fixed, else to the port != last_grant.
module biu_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  input  logic       i_fixed,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_fixed || !i_last_grant) ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/biu_bus_arbiter.sv
// Shares one cache bus unit between the fetch (port 0) and load/store (port 1) biu_cells:
// grants, latches the winning command, routes responses to the owner and times out dead transfers.
module biu_bus_arbiter
  import biu_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = FCU_IADDR_WIDTH,
  parameter int DATA_W     = FCU_DDATA_WIDTH,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  biu_bus_arbiter_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e        r_state, w_state_nxt;
  logic              r_last_grant;
  logic [1:0]        r_owner;
  cmd_type_t         r_cmd;
  logic [3:0]        r_size;
  logic [ADDR_W-1:0] r_pa;
  logic [DATA_W-1:0] r_wt_data;
  logic [CNT_W-1:0]  r_cnt;

  logic       w_req0, w_req1, w_win, w_fixed;
  logic [1:0] w_grant;
  logic       w_busy, w_resp, w_timeout, w_own0, w_own1;
  cmd_type_t  w_cmd0, w_cmd1;

  assign w_req0  = bus.p0_wt_req | bus.p0_read_req | bus.p0_line_req;
  assign w_req1  = bus.p1_wt_req | bus.p1_read_req | bus.p1_line_req;
  assign w_cmd0  = pick_type(bus.p0_wt_req, bus.p0_line_req, bus.p0_read_req);
  assign w_cmd1  = pick_type(bus.p1_wt_req, bus.p1_line_req, bus.p1_read_req);
  assign w_fixed = (FIXED_PRIO != 0);

  biu_rr_pick u_pick (
    .i_req        ({w_req1, w_req0}),
    .i_last_grant (r_last_grant),
    .i_fixed      (w_fixed),
    .o_grant      (w_grant)
  );

  assign w_win  = w_grant[1];
  assign w_busy = (r_state == ARB_BUSY);
  assign w_resp = bus.trans_rdy | bus.bus_error;
  // Counter starts at 0 on the first BUSY cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle.
  assign w_timeout = (TIMEOUT != 0) && w_busy && (r_cnt == CNT_W'(TIMEOUT - 1)) && !w_resp;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:    if (w_req0 || w_req1) w_state_nxt = ARB_BUSY;
      ARB_BUSY:    if (w_resp || w_timeout) w_state_nxt = ARB_RELEASE;
      ARB_RELEASE: w_state_nxt = ARB_IDLE;
      default:     w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 2'b00;
      r_cmd        <= '0;
      r_size       <= '0;
      r_pa         <= '0;
      r_wt_data    <= '0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ARB_IDLE: begin
          if (w_req0 || w_req1) begin
            r_owner      <= w_grant;
            r_last_grant <= w_win;
            r_cnt        <= '0;
            r_cmd        <= w_win ? w_cmd1 : w_cmd0;
            r_size       <= w_win ? bus.p1_size : bus.p0_size;
            r_pa         <= w_win ? bus.p1_pa : bus.p0_pa;
            r_wt_data    <= w_win ? bus.p1_wt_data : bus.p0_wt_data;
          end
        end
        ARB_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_resp || w_timeout) r_cmd <= '0;
        end
        ARB_RELEASE: r_owner <= 2'b00;
        default: ;
      endcase
    end
  end

  // Bus-unit command is visible only while BUSY; the latched copy keeps it stable if the port withdraws.
  assign bus.wt_req    = w_busy & r_cmd.wt;
  assign bus.read_req  = w_busy & r_cmd.read;
  assign bus.line_req  = w_busy & r_cmd.line;
  assign bus.size_o    = w_busy ? r_size : '0;
  assign bus.pa_o      = w_busy ? r_pa : '0;
  assign bus.wt_data_o = w_busy ? r_wt_data : '0;

  assign w_own0 = w_busy & (r_owner == 2'b01);
  assign w_own1 = w_busy & (r_owner == 2'b10);

  assign bus.p0_line_write  = w_own0 & bus.line_write;
  assign bus.p0_entry_write = w_own0 & bus.cache_entry_write;
  assign bus.p0_trans_rdy   = w_own0 & bus.trans_rdy;
  assign bus.p0_bus_error   = w_own0 & (bus.bus_error | w_timeout);
  assign bus.p1_line_write  = w_own1 & bus.line_write;
  assign bus.p1_entry_write = w_own1 & bus.cache_entry_write;
  assign bus.p1_trans_rdy   = w_own1 & bus.trans_rdy;
  assign bus.p1_bus_error   = w_own1 & (bus.bus_error | w_timeout);

  // Line data is common to both ports; it is held at 0 outside a transfer.
  assign bus.line_data_o  = w_busy ? bus.line_data : '0;
  assign bus.addr_count_o = w_busy ? bus.addr_count : '0;

  assign bus.owner = r_owner;
  assign bus.state = r_state;

endmodule
